oka_seq_mult: RTL and testbench

//  Parametrised, sequential odd-even Karatsuba (OKA) GF(2)[x] polynomial multiplier.

---
 rtl/oka_seq_mult.sv | 150 +++++++++++++++
 tb/tb_oka_seq_mult.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/oka_seq_mult.sv
// Sequential odd-even Karatsuba GF(2)[x] multiplier: one HALF x HALF carry-less
// multiplier is time-shared over three cycles, then the partial products are interleaved.
module oka_seq_mult #(
  parameter int N = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);

  localparam int HALF = N / 2;

  generate
    if (((N % 2) != 0) || (N < 4)) begin : g_badN
      $error("oka_seq_mult: N must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic [HALF-1:0]  w_ae, w_ao, w_be, w_bo;
  logic [HALF-1:0]  r_ae, r_ao, r_be, r_bo;
  logic [HALF-1:0]  w_opA, w_opB;
  logic [N-2:0]     w_prod;
  logic [N-2:0]     r_p0, r_p1;
  logic [N-1:0]     w_p0x, w_p1s;
  logic [2*N-2:0]   w_y;
  logic [2*N-2:0]   r_y;
  logic             r_outValid;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_outValid;
  assign y         = r_y;

  always_comb begin
    w_ae = '0;
    w_ao = '0;
    w_be = '0;
    w_bo = '0;
    for (int k = 0; k < HALF; k++) begin
      w_ae[k] = a[2*k];
      w_ao[k] = a[2*k+1];
      w_be[k] = b[2*k];
      w_bo[k] = b[2*k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_MUL0;
      S_MUL0:  w_nextState = S_MUL1;
      S_MUL1:  w_nextState = S_MUL2;
      S_MUL2:  w_nextState = S_DONE;
      S_DONE:  if (out_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Shared sub-multiplier: operands steered by state (MUL2 feeds the Karatsuba middle term).
  always_comb begin
    w_opA = r_ae;
    w_opB = r_be;
    case (r_state)
      S_MUL1: begin
        w_opA = r_ao;
        w_opB = r_bo;
      end
      S_MUL2: begin
        w_opA = r_ae ^ r_ao;
        w_opB = r_be ^ r_bo;
      end
      default: ;
    endcase
    w_prod = '0;
    for (int i = 0; i < HALF; i++) begin
      for (int j = 0; j < HALF; j++) begin
        w_prod[i+j] = w_prod[i+j] ^ (w_opA[i] & w_opB[j]);
      end
    end
  end

  // Even bits take P0 plus P1 shifted by one (x^2); odd bits take the middle term.
  always_comb begin
    w_p0x = {1'b0, r_p0};
    w_p1s = {r_p1, 1'b0};
    w_y   = '0;
    for (int i = 0; i < N; i++) begin
      w_y[2*i] = w_p0x[i] ^ w_p1s[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      w_y[2*i+1] = w_prod[i] ^ r_p0[i] ^ r_p1[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ae       <= '0;
      r_ao       <= '0;
      r_be       <= '0;
      r_bo       <= '0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_y        <= '0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ae <= w_ae;
        r_ao <= w_ao;
        r_be <= w_be;
        r_bo <= w_bo;
      end
      if (r_state == S_MUL0) r_p0 <= w_prod;
      if (r_state == S_MUL1) r_p1 <= w_prod;
      if (r_state == S_MUL2) begin
        r_y        <= w_y;
        r_outValid <= 1'b1;
      end else if ((r_state == S_DONE) && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oka_seq_mult.sv
// Self-checking bench for oka_seq_mult: directed cases plus random operands (N=30 and N=8)
// compared against a schoolbook shift-and-xor carry-less product.
module tb_oka_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [29:0] opA;
  logic [29:0] opB;
  logic        inReady;
  logic        outValid;
  logic [58:0] yOut;
  logic        busyOut;
  logic        inReady8;
  logic        outValid8;
  logic [14:0] yOut8;
  logic        busyOut8;

  int numChecks;
  int numFails;

  oka_seq_mult #(.N(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .out_valid (outValid),
    .out_ready (outReady),
    .y         (yOut),
    .busy      (busyOut)
  );

  oka_seq_mult #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady8),
    .a         (opA[7:0]),
    .b         (opB[7:0]),
    .out_valid (outValid8),
    .out_ready (outReady),
    .y         (yOut8),
    .busy      (busyOut8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain schoolbook carry-less product of two n-bit polynomials.
  function automatic logic [63:0] clmulRef(input logic [63:0] x, input logic [63:0] z, input int n);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      if (z[i]) acc = acc ^ (x << i);
    end
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [29:0] aVal, input logic [29:0] bVal,
                               input int stall, input bit fullChecks);
    logic [63:0] exp30;
    logic [63:0] exp8;
    int          edges;
    exp30 = clmulRef({34'b0, aVal}, {34'b0, bVal}, 30);
    exp8  = clmulRef({56'b0, aVal[7:0]}, {56'b0, bVal[7:0]}, 8);
    checkOutput("readyBeforeIssue", {63'b0, inReady}, 64'd1);
    inValid = 1'b1;
    opA     = aVal;
    opB     = bVal;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    opA     = $urandom;
    opB     = $urandom;
    edges   = 0;
    while (!outValid && edges < 10) begin
      if (fullChecks) begin
        checkOutput("inReadyBusy", {63'b0, inReady}, 64'd0);
        checkOutput("busyHigh", {63'b0, busyOut}, 64'd1);
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 64'(edges), 64'd3);
    checkOutput("y30", {5'b0, yOut}, exp30);
    checkOutput("y8", {49'b0, yOut8}, exp8);
    checkOutput("outValid8", {63'b0, outValid8}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      inValid = 1'b1;
      opA     = $urandom;
      opB     = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (fullChecks) begin
        checkOutput("stallValid", {63'b0, outValid}, 64'd1);
        checkOutput("stallY", {5'b0, yOut}, exp30);
        checkOutput("stallNoAccept", {63'b0, inReady}, 64'd0);
      end
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("validDrop", {63'b0, outValid}, 64'd0);
    checkOutput("backToIdle", {63'b0, inReady}, 64'd1);
    if (fullChecks) begin
      checkOutput("busyLow", {63'b0, busyOut}, 64'd0);
      checkOutput("yHeld", {5'b0, yOut}, exp30);
    end
  endtask

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst_n     = 1'b0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    opA       = '0;
    opB       = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstOutValid", {63'b0, outValid}, 64'd0);
    checkOutput("rstY", {5'b0, yOut}, 64'd0);
    checkOutput("rstBusy", {63'b0, busyOut}, 64'd0);
    checkOutput("rstInReady", {63'b0, inReady}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(30'd1, 30'd1, 0, 1'b1);
    checkOutput("oneTimesOne", {5'b0, yOut}, 64'd1);
    applyStimulus(30'h3, 30'h3, 1, 1'b1);
    checkOutput("threeSquared", {5'b0, yOut}, 64'd5);
    applyStimulus(30'd1 << 29, 30'd1 << 29, 0, 1'b1);
    checkOutput("topBits", {5'b0, yOut}, 64'd1 << 58);
    applyStimulus(30'h3FFFFFFF, 30'd1, 0, 1'b1);
    checkOutput("allOnesTimesOne", {5'b0, yOut}, 64'h3FFFFFFF);
    applyStimulus(30'h3FFFFFFF, 30'h3FFFFFFF, 0, 1'b1);
    applyStimulus(30'h2AAAAAAA, 30'h15555555, 6, 1'b1);

    // Abort in MUL1: outputs must clear asynchronously, before any clock edge.
    inValid = 1'b1;
    opA     = 30'h3;
    opB     = 30'h5;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abortOutValid", {63'b0, outValid}, 64'd0);
    checkOutput("abortY", {5'b0, yOut}, 64'd0);
    checkOutput("abortBusy", {63'b0, busyOut}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(30'd5, 30'd7, 0, 1'b1);
    checkOutput("fiveTimesSeven", {5'b0, yOut}, 64'd27);

    for (int n = 0; n < 2000; n++) begin
      applyStimulus(30'($urandom), 30'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
